dot_product_mac: RTL and testbench

- Streaming, parametrised multiply-accumulate engine: consumes one operand pair per cycle and returns the dot product of a vector of up to `LEN` unsigned pairs.
- Successor to the combinational 16-term multiply/adder-tree datapath. It replaces the replicated multipliers with one pipelined multiplier and an accumulator.
- Adds valid/ready handshakes on both sides, variable vector length via `in_last`, and an optional saturating output stage.
- Sits between the tile's input-pin unpacker and its output register.

---
 rtl/dot_product_mac.sv | 125 ++++++++++++
 tb/tb_dot_product_mac.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_mac.sv
// dot_product_mac: streaming unsigned dot-product engine.
// One operand pair per cycle goes through a registered multiplier and an
// accumulator; the result is presented with a valid/ready handshake.
// Optional feature macro: DOTP_SATURATE_EN. When it is defined, results above
// 2^OUT_W-1 are clamped and flagged on out_sat. When it is undefined, results
// wrap modulo 2^OUT_W and out_sat stays 0.
module dot_product_mac #(
    parameter  int unsigned DATA_W = 4,
    parameter  int unsigned LEN    = 16,
    parameter  int unsigned OUT_W  = 8,
    localparam int unsigned ACC_W  = 2 * DATA_W + $clog2(LEN),
    localparam int unsigned CNT_W  = $clog2(LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_sat
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    logic [PROD_W-1:0]   p;
    logic                p_valid;
    logic [ACC_W-1:0]    acc;
    logic [CNT_W-1:0]    cnt;

    logic                accept_c;
    logic                final_c;
    logic [PROD_W-1:0]   prod_c;
    logic [ACC_W-1:0]    acc_next_c;
    logic [OUT_W-1:0]    res_c;
    logic                sat_c;

    // Handshake flags decoded straight from the state register
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);

    assign accept_c   = in_valid & in_ready;
    assign final_c    = in_last | (cnt == CNT_W'(LEN - 1));
    assign prod_c     = PROD_W'(in_a) * PROD_W'(in_b);
    // Accumulator value including the product currently in stage 1
    assign acc_next_c = p_valid ? (acc + ACC_W'(p)) : acc;

`ifdef DOTP_SATURATE_EN
    localparam int unsigned EXT_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;

    logic [EXT_W-1:0] acc_ext_c;
    logic [EXT_W-1:0] out_max_c;

    assign acc_ext_c = EXT_W'(acc_next_c);
    assign out_max_c = EXT_W'({OUT_W{1'b1}});
    assign sat_c     = (acc_ext_c > out_max_c);
    assign res_c     = sat_c ? {OUT_W{1'b1}} : acc_ext_c[OUT_W-1:0];
`else
    assign sat_c = 1'b0;
    assign res_c = OUT_W'(acc_next_c);
`endif

    // Multiplier/accumulator pipeline and vector control FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            p         <= '0;
            p_valid   <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else begin
            p_valid <= accept_c;
            if (accept_c) begin
                p <= prod_c;
            end
            if (p_valid) begin
                acc <= acc_next_c;
            end

            case (state)
                ACCUM: begin
                    if (accept_c) begin
                        cnt <= cnt + CNT_W'(1);
                        if (final_c) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Last product lands in acc on this edge; capture it too
                    out_data  <= res_c;
                    out_count <= cnt;
                    out_sat   <= sat_c;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        acc     <= '0;
                        cnt     <= '0;
                        p_valid <= 1'b0;
                        state   <= ACCUM;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dot_product_mac.sv
// Self-checking bench for dot_product_mac (default parameters).
// Expected results are queued when the last pair of a vector is driven and
// are checked by a monitor when the output handshake happens.
module tb_dot_product_mac;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned LEN    = 16;
    localparam int unsigned OUT_W  = 8;
    localparam int unsigned CNT_W  = 5;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic [CNT_W-1:0] count;
        logic             sat;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic [CNT_W-1:0]  out_count;
    logic              out_sat;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    dot_product_mac #(
        .DATA_W(DATA_W),
        .LEN   (LEN),
        .OUT_W (OUT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_count(out_count),
        .out_sat  (out_sat)
    );

    always #5 clk = ~clk;

    // Reference model: exact sum -> expected output word, count and flag
    function automatic exp_t model(input int sum, input int count);
        exp_t e;
        e.count = CNT_W'(count);
`ifdef DOTP_SATURATE_EN
        if (sum > 255) begin
            e.data = 8'hFF;
            e.sat  = 1'b1;
        end else begin
            e.data = OUT_W'(sum);
            e.sat  = 1'b0;
        end
`else
        e.data = OUT_W'(sum % 256);
        e.sat  = 1'b0;
`endif
        return e;
    endfunction

    // Scoreboard: compare every completed output handshake with the queue
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            exp_t e;
            checks = checks + 1;
            if (sb_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL sb_unexpected: got data=%0d count=%0d, required no result", out_data, out_count);
            end else begin
                e = sb_q.pop_front();
                if (out_data !== e.data || out_count !== e.count || out_sat !== e.sat) begin
                    errors = errors + 1;
                    $display("FAIL sb_result: got data=%0d count=%0d sat=%0b, required data=%0d count=%0d sat=%0b",
                             out_data, out_count, out_sat, e.data, e.count, e.sat);
                end
            end
        end
    end

    // Present one pair and hold it until accepted; returns 1 ns after the accept edge
    task automatic push_pair(input int a, input int b, input logic last);
        int t = 0;
        logic acc_seen;
        in_a     = DATA_W'(a);
        in_b     = DATA_W'(b);
        in_last  = last;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            acc_seen = in_ready;
            @(posedge clk);
            #1;
            if (acc_seen) break;
            t++;
            if (t > 200) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL push_timeout: in_ready stuck at %0b, required 1", in_ready);
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Send n copies of (a,b), last pair flagged when use_last, optional random gaps
    task automatic send_vec(input int n, input int a, input int b, input logic use_last, input logic gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            push_pair(a, b, use_last && (i == n - 1));
        end
        sb_q.push_back(model(n * a * b, n));
    endtask

    // Raise out_ready until the result is taken; returns 1 ns after the handshake edge
    task automatic take_output();
        int t = 0;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (out_valid) break;
            t++;
            if (t > 200) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL out_timeout: out_valid stuck at %0b, required 1", out_valid);
                break;
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks = checks + 1;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL reset_handshake: in_ready=%0b out_valid=%0b, required 1 0", in_ready, out_valid);
        end
        checks = checks + 1;
        if (out_data !== 8'd0 || out_count !== 5'd0 || out_sat !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL reset_outputs: data=%0d count=%0d sat=%0b, required 0 0 0", out_data, out_count, out_sat);
        end
        rst = 1'b0;
    endtask

    task automatic test_full_vector();
        send_vec(16, 3, 5, 1'b0, 1'b0);
        checks = checks + 1;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL full_after_last: in_ready=%0b out_valid=%0b, required 0 0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        checks = checks + 1;
        if (out_valid !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL full_latency: out_valid=%0b two edges after last accept, required 1", out_valid);
        end
        take_output();
        checks = checks + 1;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL full_release: out_valid=%0b in_ready=%0b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_overflow();
        send_vec(16, 15, 15, 1'b0, 1'b0);
        take_output();
    endtask

    task automatic test_short_vectors();
        push_pair(1, 2, 1'b0);
        push_pair(3, 4, 1'b0);
        push_pair(5, 6, 1'b1);
        sb_q.push_back(model(44, 3));
        take_output();
        // single-element vector
        send_vec(1, 7, 9, 1'b1, 1'b0);
        take_output();
        // in_last coinciding with the length cap is one final event
        send_vec(16, 2, 3, 1'b1, 1'b0);
        take_output();
    endtask

    task automatic test_backpressure();
        logic [OUT_W-1:0] d0;
        logic [CNT_W-1:0] c0;
        int t = 0;
        send_vec(4, 2, 3, 1'b1, 1'b0);
        while (out_valid !== 1'b1 && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        d0 = out_data;
        c0 = out_count;
        checks = checks + 1;
        if (out_valid !== 1'b1 || d0 !== 8'd24 || c0 !== 5'd4) begin
            errors = errors + 1;
            $display("FAIL bp_result: valid=%0b data=%0d count=%0d, required 1 24 4", out_valid, d0, c0);
        end
        in_a     = 4'd15;
        in_b     = 4'd15;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks = checks + 1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== d0 || out_count !== c0) begin
                errors = errors + 1;
                $display("FAIL bp_hold cycle %0d: valid=%0b ready=%0b data=%0d count=%0d, required 1 0 %0d %0d",
                         i, out_valid, in_ready, out_data, out_count, d0, c0);
            end
        end
        in_valid = 1'b0;
        take_output();
        send_vec(16, 1, 1, 1'b0, 1'b0);
        take_output();
    endtask

    task automatic test_bubbles();
        send_vec(16, 2, 7, 1'b0, 1'b1);
        take_output();
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 7; i++) push_pair(9, 9, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks = checks + 1;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'd0 || out_count !== 5'd0 || out_sat !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL midreset_state: ready=%0b valid=%0b data=%0d count=%0d sat=%0b, required 1 0 0 0 0",
                     in_ready, out_valid, out_data, out_count, out_sat);
        end
        send_vec(16, 1, 1, 1'b0, 1'b0);
        take_output();
    endtask

    task automatic test_back_to_back();
        send_vec(5, 4, 4, 1'b1, 1'b0);
        take_output();
        send_vec(16, 15, 1, 1'b0, 1'b0);
        take_output();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_full_vector();
        test_overflow();
        test_short_vectors();
        test_backpressure();
        test_bubbles();
        test_mid_reset();
        test_back_to_back();
        repeat (3) @(posedge clk);
        checks = checks + 1;
        if (sb_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL sb_leftover: %0d results never produced, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
